// File: rtl/if_stage.sv
// RV32I instruction fetch stage: PC, imem handshake, one-entry skid buffer and IF/ID register.
// Redirects issued while a request is in flight wait out the aborted response in StDrop.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic [6:0]  if_id_opcode
);

    typedef enum logic [0:0] {StFetch, StDrop} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic [31:0] if_id_pc_q, if_id_pc_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;

    logic        req_int;
    logic        fetch_hit;
    logic [31:0] redirect_target;

    assign redirect_target = {redirect_pc_i[31:2], 2'b00};

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_addr_d    = req_addr_q;
        skid_valid_d  = skid_valid_q;
        skid_instr_d  = skid_instr_q;
        skid_pc_d     = skid_pc_q;
        if_id_valid_d = if_id_valid_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        req_int       = 1'b0;
        imem_addr     = pc_q;
        fetch_hit     = 1'b0;

        unique case (state_q)
            StFetch: begin
                req_int   = !skid_valid_q;
                imem_addr = pc_q;
                if (redirect_i) begin
                    // Aborted request still owes a response: hold its address until it arrives.
                    if (req_int && !imem_rvalid) begin
                        state_d    = StDrop;
                        req_addr_d = pc_q;
                    end
                end else if (req_int && imem_rvalid) begin
                    fetch_hit = 1'b1;
                    pc_d      = pc_q + 32'd4;
                    if (stall_i) begin
                        skid_valid_d = 1'b1;
                        skid_instr_d = imem_rdata;
                        skid_pc_d    = pc_q;
                    end else begin
                        if_id_valid_d = 1'b1;
                        if_id_instr_d = imem_rdata;
                        if_id_pc_d    = pc_q;
                    end
                end
            end
            StDrop: begin
                req_int   = 1'b1;
                imem_addr = req_addr_q;
                if (imem_rvalid) begin
                    state_d = StFetch;
                end
            end
            default: state_d = StFetch;
        endcase

        if (redirect_i) begin
            pc_d          = redirect_target;
            if_id_valid_d = 1'b0;
            if_id_instr_d = NOP_INSTR;
            skid_valid_d  = 1'b0;
        end else if (!stall_i) begin
            // Skid full implies no request this cycle, so drain and fetch never collide.
            if (skid_valid_q) begin
                if_id_valid_d = 1'b1;
                if_id_instr_d = skid_instr_q;
                if_id_pc_d    = skid_pc_q;
                skid_valid_d  = 1'b0;
            end else if (!fetch_hit) begin
                if_id_valid_d = 1'b0;
            end
        end

        imem_req = rst_n && req_int;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StFetch;
            pc_q          <= RESET_PC;
            req_addr_q    <= RESET_PC;
            skid_valid_q  <= 1'b0;
            skid_instr_q  <= NOP_INSTR;
            skid_pc_q     <= RESET_PC;
            if_id_valid_q <= 1'b0;
            if_id_pc_q    <= RESET_PC;
            if_id_instr_q <= NOP_INSTR;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_addr_q    <= req_addr_d;
            skid_valid_q  <= skid_valid_d;
            skid_instr_q  <= skid_instr_d;
            skid_pc_q     <= skid_pc_d;
            if_id_valid_q <= if_id_valid_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
        end
    end

    assign if_id_valid  = if_id_valid_q;
    assign if_id_pc     = if_id_pc_q;
    assign if_id_instr  = if_id_instr_q;
    assign if_id_opcode = if_id_instr_q[6:0];

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: streaming, wait states, stall/skid, redirects and PC wrap.
// Inputs change and outputs are sampled at the falling clock edge.
module tb_if_stage;

    localparam logic [31:0] Xor = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic [6:0]  if_id_opcode;

    // Second instance for the PC wrap case, always with a combinational memory.
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_rvalid;
    logic [31:0] w_rdata;
    logic        w_stall = 1'b0;
    logic        w_redirect = 1'b0;
    logic [31:0] w_redirect_pc = 32'h0;
    logic        w_valid;
    logic [31:0] w_pc;
    logic [31:0] w_instr;
    logic [6:0]  w_opcode;

    int lat = 0;
    int cnt = 0;
    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    // Memory model: responds once a request has been held for lat cycles.
    assign imem_rvalid = imem_req && (cnt == lat);
    assign imem_rdata  = imem_addr ^ Xor;
    always @(posedge clk) begin
        if (!rst_n) cnt <= 0;
        else if (imem_req && !imem_rvalid) cnt <= cnt + 1;
        else cnt <= 0;
    end

    assign w_rvalid = w_req;
    assign w_rdata  = w_addr ^ Xor;

    if_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .stall_i      (stall_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .if_id_valid  (if_id_valid),
        .if_id_pc     (if_id_pc),
        .if_id_instr  (if_id_instr),
        .if_id_opcode (if_id_opcode)
    );

    if_stage #(
        .RESET_PC (32'hFFFF_FFFC),
        .NOP_INSTR(32'h0000_0013)
    ) dut_wrap (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (w_req),
        .imem_addr    (w_addr),
        .imem_rvalid  (w_rvalid),
        .imem_rdata   (w_rdata),
        .stall_i      (w_stall),
        .redirect_i   (w_redirect),
        .redirect_pc_i(w_redirect_pc),
        .if_id_valid  (w_valid),
        .if_id_pc     (w_pc),
        .if_id_instr  (w_instr),
        .if_id_opcode (w_opcode)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %b expected 0", imem_req); else passed++;
        checks++; if (if_id_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", if_id_valid); else passed++;
        checks++; if (if_id_pc !== 32'h0) $display("FAIL reset_pc: got %h expected 00000000", if_id_pc); else passed++;
        checks++; if (if_id_instr !== 32'h13) $display("FAIL reset_instr: got %h expected 00000013", if_id_instr); else passed++;
        checks++; if (if_id_opcode !== 7'h13) $display("FAIL reset_opcode: got %h expected 13", if_id_opcode); else passed++;
        rst_n = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1) $display("FAIL release_req: got %b expected 1", imem_req); else passed++;
        checks++; if (imem_addr !== 32'h0) $display("FAIL release_addr: got %h expected 00000000", imem_addr); else passed++;
    endtask

    task automatic test_stream();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (if_id_valid !== 1'b1) $display("FAIL stream_valid[%0d]: got %b expected 1", i, if_id_valid); else passed++;
            checks++; if (if_id_pc !== 32'(4 * i)) $display("FAIL stream_pc[%0d]: got %h expected %h", i, if_id_pc, 32'(4 * i)); else passed++;
            checks++; if (if_id_instr !== (32'(4 * i) ^ Xor)) $display("FAIL stream_instr[%0d]: got %h expected %h", i, if_id_instr, 32'(4 * i) ^ Xor); else passed++;
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] a;
        lat = 3;
        for (int k = 0; k < 2; k++) begin
            a = 32'h14 + 32'(4 * k);
            for (int j = 0; j < 3; j++) begin
                @(negedge clk);
                checks++; if (imem_addr !== a) $display("FAIL wait_addr[%0d.%0d]: got %h expected %h", k, j, imem_addr, a); else passed++;
                checks++; if (if_id_valid !== 1'b0) $display("FAIL wait_bubble[%0d.%0d]: got %b expected 0", k, j, if_id_valid); else passed++;
            end
            @(negedge clk);
            checks++; if (if_id_valid !== 1'b1) $display("FAIL wait_valid[%0d]: got %b expected 1", k, if_id_valid); else passed++;
            checks++; if (if_id_pc !== a) $display("FAIL wait_pc[%0d]: got %h expected %h", k, if_id_pc, a); else passed++;
        end
        lat = 0;
    endtask

    task automatic test_stall_skid();
        stall_i = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            checks++; if (if_id_pc !== 32'h18 || if_id_valid !== 1'b1) $display("FAIL stall_hold[%0d]: got pc %h valid %b expected pc 00000018 valid 1", j, if_id_pc, if_id_valid); else passed++;
            checks++; if (imem_req !== 1'b0) $display("FAIL stall_req[%0d]: got %b expected 0", j, imem_req); else passed++;
        end
        stall_i = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            checks++; if (if_id_pc !== 32'h1C + 32'(4 * j)) $display("FAIL release_pc[%0d]: got %h expected %h", j, if_id_pc, 32'h1C + 32'(4 * j)); else passed++;
            checks++; if (if_id_instr !== ((32'h1C + 32'(4 * j)) ^ Xor)) $display("FAIL release_instr[%0d]: got %h expected %h", j, if_id_instr, (32'h1C + 32'(4 * j)) ^ Xor); else passed++;
        end
    endtask

    task automatic test_redirect_wait();
        // Response arriving in the redirect cycle is dropped without entering StDrop.
        redirect_i = 1'b1;
        redirect_pc_i = 32'h10;
        @(negedge clk);
        redirect_i = 1'b0;
        lat = 3;
        checks++; if (if_id_valid !== 1'b0) $display("FAIL redir_flush_valid: got %b expected 0", if_id_valid); else passed++;
        checks++; if (if_id_opcode !== 7'h13) $display("FAIL redir_flush_opcode: got %h expected 13", if_id_opcode); else passed++;
        checks++; if (imem_addr !== 32'h10) $display("FAIL redir_target_addr: got %h expected 00000010", imem_addr); else passed++;
        @(negedge clk);
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0000_0102;
        @(negedge clk);
        redirect_i = 1'b0;
        for (int j = 0; j < 2; j++) begin
            checks++; if (imem_addr !== 32'h10 || imem_req !== 1'b1) $display("FAIL drop_hold[%0d]: got addr %h req %b expected 00000010 1", j, imem_addr, imem_req); else passed++;
            checks++; if (if_id_valid !== 1'b0) $display("FAIL drop_valid[%0d]: got %b expected 0", j, if_id_valid); else passed++;
            @(negedge clk);
        end
        for (int j = 0; j < 4; j++) begin
            checks++; if (imem_addr !== 32'h100) $display("FAIL refetch_addr[%0d]: got %h expected 00000100", j, imem_addr); else passed++;
            checks++; if (if_id_valid !== 1'b0) $display("FAIL refetch_bubble[%0d]: got %b expected 0", j, if_id_valid); else passed++;
            @(negedge clk);
        end
        checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h100) $display("FAIL refetch_pc: got valid %b pc %h expected 1 00000100", if_id_valid, if_id_pc); else passed++;
        checks++; if (if_id_instr !== (32'h100 ^ Xor)) $display("FAIL refetch_instr: got %h expected %h", if_id_instr, 32'h100 ^ Xor); else passed++;
        lat = 0;
    endtask

    task automatic test_redirect_priority();
        stall_i = 1'b1;
        @(negedge clk);
        checks++; if (imem_req !== 1'b0) $display("FAIL prio_skid_full: got req %b expected 0", imem_req); else passed++;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h200;
        @(negedge clk);
        redirect_i = 1'b0;
        checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h13) $display("FAIL prio_flush: got valid %b instr %h expected 0 00000013", if_id_valid, if_id_instr); else passed++;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) $display("FAIL prio_req: got req %b addr %h expected 1 00000200", imem_req, imem_addr); else passed++;
        stall_i = 1'b0;
        @(negedge clk);
        checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h200) $display("FAIL prio_target: got valid %b pc %h expected 1 00000200", if_id_valid, if_id_pc); else passed++;
    endtask

    task automatic test_wrap();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (w_pc !== 32'hFFFF_FFFC || w_valid !== 1'b0) $display("FAIL wrap_reset: got pc %h valid %b expected fffffffc 0", w_pc, w_valid); else passed++;
        rst_n = 1'b1;
        #1;
        checks++; if (w_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_first_addr: got %h expected fffffffc", w_addr); else passed++;
        @(negedge clk);
        checks++; if (w_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_first_pc: got %h expected fffffffc", w_pc); else passed++;
        checks++; if (w_addr !== 32'h0) $display("FAIL wrap_second_addr: got %h expected 00000000", w_addr); else passed++;
        @(negedge clk);
        checks++; if (w_pc !== 32'h0 || w_instr !== Xor) $display("FAIL wrap_second_pc: got pc %h instr %h expected 00000000 %h", w_pc, w_instr, Xor); else passed++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_wait_states();
        test_stall_skid();
        test_redirect_wait();
        test_redirect_priority();
        test_wrap();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
